// File: rtl/imm_encoder.sv
// imm_encoder: load-immediate expander.
// Turns a 32-bit constant plus a destination register into the shortest MIPS
// I-type sequence that rebuilds it (addiu / ori / lui / lui+ori), streamed out
// one word at a time.
//
// Optional feature macro: LI_ADDIU_EN
//   defined   -> sign-extendable constants use a single addiu.
//   undefined -> no addiu is emitted; such constants fall through to ori/lui/lui+ori.
//
// Handshake (both ports): a transfer happens on a rising clk edge where
// valid & ready are both high. A producer never withdraws valid or changes its
// payload while waiting for ready, and ready never depends on valid.
// in_ready is decoded from the state register alone.
module imm_encoder #(
  parameter logic [5:0] OPC_ADDIU = 6'h09,
  parameter logic [5:0] OPC_ORI   = 6'h0D,
  parameter logic [5:0] OPC_LUI   = 6'h0F,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rt,
  input  logic [31:0]      in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_last,
  output logic [CNT_W-1:0] word_count,
  output logic [1:0]       dbgState
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT1 = 2'd1,
    EMIT2 = 2'd2
  } stateT;

  stateT       state;
  stateT       nextState;
  logic [31:0] pendWord;   // second word of the lui+ori form, held until EMIT2
  logic        pendTwo;    // current request needs the second word

  logic        useA;
  logic        useB;
  logic        useC;
  logic [31:0] firstWord;
  logic [31:0] secondWord;
  logic        twoWord;
  logic        accept;
  logic        handoff;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state != IDLE);
  assign accept    = in_valid & in_ready;
  assign handoff   = out_valid & out_ready;
  assign dbgState  = state;

  // Pick the shortest form for the incoming constant; first match wins.
  always_comb begin
`ifdef LI_ADDIU_EN
    useA = (&in_value[31:15]) | ~(|in_value[31:15]);
`else
    useA = 1'b0;
`endif
    useB       = ~(|in_value[31:16]);
    useC       = ~(|in_value[15:0]);
    twoWord    = 1'b0;
    secondWord = {OPC_ORI, in_rt, in_rt, in_value[15:0]};
    if (useA) begin
      firstWord = {OPC_ADDIU, 5'd0, in_rt, in_value[15:0]};
    end else if (useB) begin
      firstWord = {OPC_ORI, 5'd0, in_rt, in_value[15:0]};
    end else if (useC) begin
      firstWord = {OPC_LUI, 5'd0, in_rt, in_value[31:16]};
    end else begin
      firstWord = {OPC_LUI, 5'd0, in_rt, in_value[31:16]};
      twoWord   = 1'b1;
    end
  end

  // Next-state logic: advance only on handshakes.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (in_valid) nextState = EMIT1;
      EMIT1:   if (out_ready) nextState = pendTwo ? EMIT2 : IDLE;
      EMIT2:   if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State, output word registers and the handoff counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      out_instr  <= 32'd0;
      out_last   <= 1'b0;
      pendWord   <= 32'd0;
      pendTwo    <= 1'b0;
      word_count <= '0;
    end else begin
      state <= nextState;
      if (accept) begin
        out_instr <= firstWord;
        out_last  <= ~twoWord;
        pendWord  <= secondWord;
        pendTwo   <= twoWord;
      end else if ((state == EMIT1) && out_ready && pendTwo) begin
        out_instr <= pendWord;
        out_last  <= 1'b1;
      end
      if (handoff) begin
        word_count <= word_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed and randomized checks of imm_encoder against an
// arithmetic model of the load-immediate forms.
module tb_imm_encoder;

`ifdef LI_ADDIU_EN
  localparam bit ADDIU_EN = 1'b1;
`else
  localparam bit ADDIU_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rt;
  logic [31:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;
  logic [15:0] word_count;
  logic [1:0]  dbg_state;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_count = 16'd0;
  logic [32:0] exp_q[$];   // {last, instr}

  imm_encoder dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_rt(in_rt), .in_value(in_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_last(out_last), .word_count(word_count), .dbgState(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // reference model: instruction word from field values by plain arithmetic
  function automatic logic [31:0] mk(input int op, input int rs, input int rt, input int imm);
    return 32'(op * 67108864 + rs * 2097152 + rt * 65536 + imm);
  endfunction

  task automatic build_exp(input int rt, input logic [31:0] v);
    int sv;
    int hi;
    int lo;
    sv = $signed(v);
    hi = int'(v / 65536);
    lo = int'(v % 65536);
    if (ADDIU_EN && sv >= -32768 && sv <= 32767) begin
      exp_q.push_back({1'b1, mk(9, 0, rt, lo)});
    end else if (hi == 0) begin
      exp_q.push_back({1'b1, mk(13, 0, rt, lo)});
    end else if (lo == 0) begin
      exp_q.push_back({1'b1, mk(15, 0, rt, hi)});
    end else begin
      exp_q.push_back({1'b0, mk(15, 0, rt, hi)});
      exp_q.push_back({1'b1, mk(13, rt, rt, lo)});
    end
  endtask

  // driver: one request; mode 0 random out_ready, 1 always ready, 2 stall 5 cycles
  task automatic run_req(input logic [4:0] rt, input logic [31:0] v, input int mode);
    int cyc;
    int stall;
    bit accepted;
    bit busy;
    bit acc;
    bit pop;
    cyc = 0;
    stall = 0;
    accepted = 0;
    build_exp(rt, v);
    in_valid = 1'b1;
    in_rt    = rt;
    in_value = v;
    while (!(accepted && exp_q.size() == 0) && cyc < 50) begin
      case (mode)
        1:       out_ready = 1'b1;
        2: begin out_ready = accepted && stall >= 5; if (accepted) stall++; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      busy = accepted && exp_q.size() != 0;
      chk("in_ready", {32'd0, in_ready}, {32'd0, !busy});
      chk("out_valid", {32'd0, out_valid}, {32'd0, busy});
      chk("word_count", {17'd0, word_count}, {17'd0, exp_count});
      if (busy) chk("word", {out_last, out_instr}, exp_q[0]);
      acc = in_valid && !accepted;
      pop = busy && out_ready;
      tick();
      if (acc) begin accepted = 1; in_valid = 1'b0; end
      if (pop) begin void'(exp_q.pop_front()); exp_count++; end
      cyc++;
    end
    if (cyc >= 50) begin
      chk("timeout", {32'd0, 1'b1}, 33'd0);
      exp_q.delete();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    int kind;
    in_valid = 1'b0; in_rt = 5'd0; in_value = 32'd0; out_ready = 1'b0;
    reset = 1'b1;
    tick(); tick();
    // reset state
    chk("rst_out_valid", {32'd0, out_valid}, 33'd0);
    chk("rst_out_instr", {1'b0, out_instr}, 33'd0);
    chk("rst_out_last", {32'd0, out_last}, 33'd0);
    chk("rst_word_count", {17'd0, word_count}, 33'd0);
    chk("rst_in_ready", {32'd0, in_ready}, 33'd1);
    reset = 1'b0;
    tick();

    // two-word form and counter
    run_req(5'd8, 32'h12345678, 1);
    chk("t1_count", {17'd0, word_count}, 33'd2);
    // small negative, ori boundary, lui only
    run_req(5'd8, 32'hFFFF8000, 1);
    run_req(5'd8, 32'h00008000, 1);
    run_req(5'd8, 32'h12340000, 1);
    run_req(5'd8, 32'h00007FFF, 1);
    run_req(5'd0, 32'hFFFFFFFF, 1);
    run_req(5'd31, 32'hFFFF7FFF, 1);
    // stalled consumer holds the word
    run_req(5'd8, 32'h12345678, 2);

    // reset while the second word is pending
    build_exp(8, 32'h12345678);
    in_valid = 1'b1; in_rt = 5'd8; in_value = 32'h12345678; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("r_word1", {out_last, out_instr}, exp_q[0]);
    tick();
    chk("r_word2", {out_last, out_instr}, exp_q[1]);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    exp_count = 16'd0;
    chk("r_out_valid", {32'd0, out_valid}, 33'd0);
    chk("r_in_ready", {32'd0, in_ready}, 33'd1);
    chk("r_word_count", {17'd0, word_count}, 33'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r_no_second", {32'd0, out_valid}, 33'd0);
    end

    // back-to-back zero requests, in_valid held high
    build_exp(8, 32'd0);
    in_valid = 1'b1; in_rt = 5'd8; in_value = 32'd0; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      chk("b2b_in_ready", {32'd0, in_ready}, {32'd0, (c % 2) == 0});
      chk("b2b_out_valid", {32'd0, out_valid}, {32'd0, (c % 2) == 1});
      chk("b2b_count", {17'd0, word_count}, {17'd0, exp_count});
      if (c % 2 == 1) chk("b2b_word", {out_last, out_instr}, exp_q[0]);
      tick();
      if (c % 2 == 1) exp_count++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    exp_q.delete();

    // randomized constants across all form classes
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: v = 32'($urandom_range(0, 32767));
        1: v = 32'hFFFF0000 | 32'($urandom_range(32768, 65535));
        2: v = {16'($urandom), 16'd0};
        3: v = 32'($urandom_range(32768, 65535));
        default: v = $urandom;
      endcase
      run_req(5'($urandom_range(0, 31)), v, ($urandom_range(0, 3) == 0) ? 1 : 0);
    end
    tick();
    chk("final_count", {17'd0, word_count}, {17'd0, exp_count});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
